// File: rtl/a09_run_pkg.sv
// rtl/a09_run_pkg.sv - shared state encoding and defaults for the A09 run controller
package a09_run_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_RESET      = 3'd1,
    ST_WAIT_READY = 3'd2,
    ST_RUN        = 3'd3,
    ST_DONE       = 3'd4
  } run_state_e;

  localparam int unsigned DefRstCycles     = 2;
  localparam int unsigned DefTimeoutCycles = 250;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - up counter with sync clear and enable that sticks at all-ones
module sat_counter #(
  parameter int unsigned Width = 16
) (
  input  logic             clk_i,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [Width-1:0] cnt_o
);

  localparam logic [Width-1:0] One = Width'(1);

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + One;
    end
  end

  always_ff @(posedge clk_i) begin
    cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/cpu_run_controller.sv
// rtl/cpu_run_controller.sv - sequences one A09 CPU run: reset, wait ready, run to halt or watchdog
// Optional CpuOut trace (OutChanges, FirstOut) when A09_OUT_TRACE_EN is defined.
module cpu_run_controller
  import a09_run_pkg::*;
#(
  parameter int unsigned DataWidth     = 16,
  parameter int unsigned CntWidth      = 16,
  parameter int unsigned RstCycles     = DefRstCycles,
  parameter int unsigned TimeoutCycles = DefTimeoutCycles
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 Start,
  input  logic [DataWidth-1:0] Expected,
  input  logic                 CpuReady,
  input  logic                 CpuHalt,
  input  logic [DataWidth-1:0] CpuOut,
  output logic                 CpuReset_n,
  output logic                 Busy,
  output logic                 Done,
  output logic                 Pass,
  output logic                 Timeout,
  output logic [CntWidth-1:0]  CycleCount,
  output logic [DataWidth-1:0] OutCapture
`ifdef A09_OUT_TRACE_EN
  ,
  output logic [CntWidth-1:0]  OutChanges,
  output logic [DataWidth-1:0] FirstOut
`endif
);

  localparam int unsigned RcW = (RstCycles > 1) ? $clog2(RstCycles) : 1;
  localparam logic [RcW-1:0]      RstLoad = RcW'(RstCycles - 1);
  localparam logic [RcW-1:0]      RcOne   = RcW'(1);
  localparam logic [CntWidth-1:0] WdLimit = CntWidth'(TimeoutCycles - 1);

  run_state_e state_q, state_d;
  logic [RcW-1:0]       rst_cnt_q, rst_cnt_d;
  logic                 cpu_rst_n_q, cpu_rst_n_d;
  logic                 pass_q, pass_d;
  logic                 timeout_q, timeout_d;
  logic [DataWidth-1:0] out_cap_q, out_cap_d;
  logic                 start_accept;
  logic                 wd_fire;
  logic                 cnt_en;

  always_comb begin
    state_d      = state_q;
    rst_cnt_d    = rst_cnt_q;
    pass_d       = pass_q;
    timeout_d    = timeout_q;
    out_cap_d    = out_cap_q;
    start_accept = 1'b0;
    wd_fire      = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (Start) begin
          state_d      = ST_RESET;
          rst_cnt_d    = RstLoad;
          pass_d       = 1'b0;
          timeout_d    = 1'b0;
          out_cap_d    = '0;
          start_accept = 1'b1;
        end
      end
      ST_RESET: begin
        if (rst_cnt_q == '0) state_d = ST_WAIT_READY;
        else                 rst_cnt_d = rst_cnt_q - RcOne;
      end
      ST_WAIT_READY, ST_RUN: begin
        // The Ready/Halt event takes priority over a watchdog expiring in the same cycle.
        if ((state_q == ST_WAIT_READY) && CpuReady) begin
          state_d = ST_RUN;
        end else if ((state_q == ST_RUN) && CpuHalt) begin
          state_d   = ST_DONE;
          out_cap_d = CpuOut;
          pass_d    = (CpuOut == Expected);
        end else if (CycleCount == WdLimit) begin
          wd_fire   = 1'b1;
          state_d   = ST_DONE;
          timeout_d = 1'b1;
          pass_d    = 1'b0;
          out_cap_d = CpuOut;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    cpu_rst_n_d = (state_d == ST_WAIT_READY) || (state_d == ST_RUN) || (state_d == ST_DONE);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= ST_IDLE;
      rst_cnt_q   <= '0;
      cpu_rst_n_q <= 1'b0;
      pass_q      <= 1'b0;
      timeout_q   <= 1'b0;
      out_cap_q   <= '0;
    end else begin
      state_q     <= state_d;
      rst_cnt_q   <= rst_cnt_d;
      cpu_rst_n_q <= cpu_rst_n_d;
      pass_q      <= pass_d;
      timeout_q   <= timeout_d;
      out_cap_q   <= out_cap_d;
    end
  end

  // The watchdog edge itself is not counted, so a timeout leaves TimeoutCycles-1.
  assign cnt_en = ((state_q == ST_WAIT_READY) || (state_q == ST_RUN)) && !wd_fire;

  sat_counter #(.Width(CntWidth)) u_cycle_cnt (
    .clk_i (Clk),
    .clr_i (Reset || start_accept),
    .en_i  (cnt_en),
    .cnt_o (CycleCount)
  );

  assign CpuReset_n = cpu_rst_n_q;
  assign Busy       = (state_q == ST_RESET) || (state_q == ST_WAIT_READY) || (state_q == ST_RUN);
  assign Done       = (state_q == ST_DONE);
  assign Pass       = pass_q;
  assign Timeout    = timeout_q;
  assign OutCapture = out_cap_q;

`ifdef A09_OUT_TRACE_EN
  logic [DataWidth-1:0] prev_out_q;
  logic [DataWidth-1:0] first_out_q;
  logic                 first_seen_q;
  logic                 out_changed;

  assign out_changed = (state_q == ST_RUN) && (CpuOut != prev_out_q);

  sat_counter #(.Width(CntWidth)) u_change_cnt (
    .clk_i (Clk),
    .clr_i (Reset || start_accept),
    .en_i  (out_changed),
    .cnt_o (OutChanges)
  );

  always_ff @(posedge Clk) begin
    if (Reset || start_accept) begin
      prev_out_q   <= CpuOut;
      first_out_q  <= '0;
      first_seen_q <= 1'b0;
    end else begin
      prev_out_q <= CpuOut;
      if (out_changed && !first_seen_q) begin
        first_out_q  <= CpuOut;
        first_seen_q <= 1'b1;
      end
    end
  end

  assign FirstOut = first_out_q;
`endif

endmodule

// File: tb/tb_cpu_run_controller.sv
// tb/tb_cpu_run_controller.sv - directed self-checking bench for cpu_run_controller
module tb_cpu_run_controller;

  logic        Clk = 1'b0;
  logic        Reset, Start, CpuReady, CpuHalt;
  logic [15:0] Expected, CpuOut;
  logic        CpuReset_n, Busy, Done, Pass, Timeout;
  logic [15:0] CycleCount, OutCapture;
`ifdef A09_OUT_TRACE_EN
  logic [15:0] OutChanges, FirstOut;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 Clk = ~Clk;

  cpu_run_controller dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .Start      (Start),
    .Expected   (Expected),
    .CpuReady   (CpuReady),
    .CpuHalt    (CpuHalt),
    .CpuOut     (CpuOut),
    .CpuReset_n (CpuReset_n),
    .Busy       (Busy),
    .Done       (Done),
    .Pass       (Pass),
    .Timeout    (Timeout),
    .CycleCount (CycleCount),
    .OutCapture (OutCapture)
`ifdef A09_OUT_TRACE_EN
    ,
    .OutChanges (OutChanges),
    .FirstOut   (FirstOut)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp_v);
    n_checks++;
    if (got !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp_v);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // Start pulse, verify results cleared, then measure the CPU reset pulse width.
  task automatic start_and_reset(input string tag);
    int rl;
    Start = 1'b1;
    step();
    Start = 1'b0;
    check({tag, "_clr_pass"}, Pass, 0);
    check({tag, "_clr_cnt"}, CycleCount, 0);
    check({tag, "_clr_out"}, OutCapture, 0);
    check({tag, "_busy"}, Busy, 1);
    rl = 0;
    while (!CpuReset_n && rl < 10) begin
      rl++;
      step();
    end
    check({tag, "_rst_low"}, rl, 2);
  endtask

  task automatic do_run(input string tag, input int ready_at, input int halt_after,
                        input logic [15:0] out_v, input logic [15:0] exp_v);
    CpuOut   = out_v;
    Expected = exp_v;
    start_and_reset(tag);
    for (int i = 1; i <= ready_at; i++) begin
      CpuReady = (i == ready_at);
      step();
    end
    CpuReady = 1'b0;
    for (int i = 1; i <= halt_after; i++) begin
      CpuHalt = (i == halt_after);
      step();
    end
    CpuHalt = 1'b0;
  endtask

  initial begin
    int wc;
    logic [15:0] seq [5];
    seq = '{16'd0, 16'd1, 16'd1, 16'd2, 16'd3};

    Reset = 1'b1; Start = 1'b0; CpuReady = 1'b0; CpuHalt = 1'b0;
    Expected = '0; CpuOut = '0;
    step();
    step();
    Reset = 1'b0;
    step();
    check("rst_cpu_rst_n", CpuReset_n, 0);
    check("rst_busy", Busy, 0);
    check("rst_done", Done, 0);
    check("rst_pass", Pass, 0);
    check("rst_timeout", Timeout, 0);
    check("rst_cnt", CycleCount, 0);
    check("rst_out", OutCapture, 0);

    do_run("normal", 3, 20, 16'h0042, 16'h0042);
    check("normal_done", Done, 1);
    check("normal_pass", Pass, 1);
    check("normal_timeout", Timeout, 0);
    check("normal_out", OutCapture, 16'h0042);
    check("normal_cnt", CycleCount, 23);
    check("normal_rst_n", CpuReset_n, 1);

    do_run("mismatch", 3, 20, 16'h0042, 16'h0041);
    check("mismatch_done", Done, 1);
    check("mismatch_pass", Pass, 0);
    check("mismatch_timeout", Timeout, 0);
    check("mismatch_out", OutCapture, 16'h0042);

    CpuOut   = 16'h00ab;
    Expected = 16'h00ab;
    start_and_reset("wd");
    wc = 0;
    while (!Done && wc < 300) begin
      wc++;
      step();
    end
    check("wd_wait_cycles", wc, 250);
    check("wd_timeout", Timeout, 1);
    check("wd_pass", Pass, 0);
    check("wd_cnt", CycleCount, 249);
    check("wd_out", OutCapture, 16'h00ab);

    do_run("tie", 1, 249, 16'h0042, 16'h0042);
    check("tie_done", Done, 1);
    check("tie_timeout", Timeout, 0);
    check("tie_pass", Pass, 1);
    check("tie_cnt", CycleCount, 250);

`ifdef A09_OUT_TRACE_EN
    CpuOut   = 16'd0;
    Expected = 16'd3;
    start_and_reset("trace");
    check("trace_clr_changes", OutChanges, 0);
    check("trace_clr_first", FirstOut, 0);
    CpuReady = 1'b1;
    step();
    CpuReady = 1'b0;
    for (int i = 0; i < 5; i++) begin
      CpuOut  = seq[i];
      CpuHalt = (i == 4);
      step();
    end
    CpuHalt = 1'b0;
    check("trace_done", Done, 1);
    check("trace_pass", Pass, 1);
    check("trace_changes", OutChanges, 3);
    check("trace_first", FirstOut, 1);
`endif

    CpuOut   = 16'h0042;
    Expected = 16'h0042;
    start_and_reset("abort");
    CpuReady = 1'b1;
    step();
    CpuReady = 1'b0;
    for (int i = 0; i < 5; i++) step();
    check("abort_cnt_mid", CycleCount, 6);
    Start = 1'b1;
    step();
    Start = 1'b0;
    check("busy_start_ignored_cnt", CycleCount, 7);
    check("busy_start_ignored_busy", Busy, 1);
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    check("abort_busy", Busy, 0);
    check("abort_done", Done, 0);
    check("abort_rst_n", CpuReset_n, 0);
    check("abort_cnt", CycleCount, 0);
    check("abort_pass", Pass, 0);
    check("abort_out", OutCapture, 0);
    step();
    check("abort_idle_hold", Busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu_run_controller.md
Name: cpu_run_controller

Overview:
- Synthesizable run controller that replaces fixed-delay bench sequencing for the A09 CPU.
- Drives the CPU's active-low reset for a programmable number of cycles, then waits for CPU Ready.
- Runs the program until Halt or a watchdog timeout, captures OutReg, compares it with an expected value, and reports cycle count and pass/fail.
- Sits between the bench (or an FPGA top) and the CPU instance; one instance per CPU.

Parameters:
- DataWidth, 16, width of CPU OutReg and of Expected.
- CntWidth, 16, width of the cycle counter.
- RstCycles, 2, number of cycles CpuReset_n is held low per run; must be ≥1.
- TimeoutCycles, 250, watchdog limit in cycles, counted across WAIT_READY and RUN; must be ≥2 and < 2^CntWidth.

Ports:
- Clk  in  1  system clock; all logic on posedge.
- Reset  in  1  synchronous, active-high controller reset.
- Start  in  1  single-cycle run request.
- Expected  in  DataWidth  expected OutReg value at Halt.
- CpuReady  in  1  CPU Ready (ControlMatrix reached S_Ready).
- CpuHalt  in  1  CPU Halt.
- CpuOut  in  DataWidth  CPU OutReg.
- CpuReset_n  out  1  active-low reset to the CPU.
- Busy  out  1  high in RESET, WAIT_READY and RUN.
- Done  out  1  high in DONE.
- Pass  out  1  run halted and OutCapture == Expected.
- Timeout  out  1  run ended by the watchdog.
- CycleCount  out  CntWidth  cycles spent in WAIT_READY+RUN for the last or current run.
- OutCapture  out  DataWidth  CpuOut sampled on the halt edge.

Behaviour:
- One clock domain (Clk). Reset is synchronous and active-high and overrides everything in the same edge.
- Reset values:
  - state = IDLE, CpuReset_n = 0.
  - Busy, Done, Pass and Timeout = 0.
  - CycleCount and OutCapture = 0.
- States: IDLE, RESET, WAIT_READY, RUN, DONE.
- IDLE:
  - CpuReset_n = 0, so the CPU is parked.
  - Start=1 → RESET. The same edge loads the reset counter with RstCycles-1 and clears CycleCount, Pass, Timeout and OutCapture.
- RESET:
  - CpuReset_n = 0.
  - The counter decrements each cycle; at 0 → WAIT_READY.
  - CpuReset_n is low for exactly RstCycles cycles after leaving IDLE/DONE.
- WAIT_READY:
  - CpuReset_n = 1; CycleCount increments every cycle.
  - CpuReady=1 → RUN.
  - CpuHalt is ignored in this state.
- RUN:
  - CpuReset_n = 1; CycleCount increments.
  - CpuHalt=1 → DONE. The same edge captures OutCapture <= CpuOut and sets Pass <= (CpuOut == Expected).
- Watchdog:
  - In WAIT_READY or RUN, if CycleCount == TimeoutCycles-1 and no Ready/Halt event occurs that cycle → DONE with Timeout=1 and Pass=0.
  - OutCapture <= CpuOut on the same edge, for debug.
- Simultaneous events: Halt (in RUN) or Ready (in WAIT_READY) in the same cycle as the watchdog limit → the event wins and Timeout stays 0.
- DONE:
  - CpuReset_n = 1, so CPU state stays inspectable.
  - All results are held stable. Start=1 → RESET (restart, results cleared).
- Start is ignored while Busy.
- CycleCount saturates at all-ones; it never wraps.
- Reset asserted mid-run → IDLE next edge, CpuReset_n drops to 0 on that edge, and results are cleared.
- Outputs are registered except Busy and Done, which are decoded from the state register.

Optional Feature:
- Macro: A09_OUT_TRACE_EN.
- Defined:
  - Adds output OutChanges (CntWidth, saturating): the count of RUN cycles where CpuOut differs from its value the previous cycle.
  - Adds output FirstOut (DataWidth): the first changed CpuOut value seen in RUN.
  - Both are cleared on Reset and on entry to RESET.
- Undefined: the ports and logic are absent; all other behaviour is identical.

Decomposition:
- Package a09_run_pkg holds:
  - the state encoding constants (IDLE=0, RESET=1, WAIT_READY=2, RUN=3, DONE=4, 3-bit);
  - the default RstCycles and TimeoutCycles.
- One sub-module, sat_counter: parametrised width, with sync clear, enable and saturate. It is used for CycleCount and, under A09_OUT_TRACE_EN, OutChanges.

Test Plan:
- Normal run:
  - Stimulus: Reset, then Start; CpuReady at cycle 3 after RESET; CpuHalt after 20 RUN cycles; CpuOut=16'h0042, Expected=16'h0042.
  - Required: CpuReset_n low exactly 2 cycles, Done=1, Pass=1, Timeout=0, OutCapture=16'h0042, CycleCount=23.
- Mismatch:
  - Stimulus: as the normal run but Expected=16'h0041.
  - Required: Done=1, Pass=0, Timeout=0, OutCapture=16'h0042.
- Watchdog:
  - Stimulus: CpuReady never asserted, TimeoutCycles=250.
  - Required: DONE after 250 WAIT_READY cycles, Timeout=1, Pass=0, CycleCount=249.
- Tie:
  - Stimulus: CpuHalt asserted in the same cycle CycleCount==TimeoutCycles-1.
  - Required: Timeout=0, Pass per compare.
- Restart and abort:
  - Stimulus: Start pulsed while Busy.
  - Required: ignored.
  - Stimulus: Reset mid-RUN.
  - Required: IDLE next edge, CpuReset_n=0, all results cleared.
  - Stimulus: Start from DONE.
  - Required: a fresh run with results cleared.
- A09_OUT_TRACE_EN:
  - Stimulus: CpuOut sequence 0,1,1,2,3 in RUN, then Halt.
  - Required: OutChanges=3, FirstOut=1.
